sidebuf_reinject: RTL and testbench
===================================

SIDEBUF_REINJECT -- requirements
Module: sidebuf_reinject

Interface
REQ-001 Parameter: FLIT_W, default 11, flit width in bits; flits are opaque to this block.
REQ-002 Parameter: DEPTH, default 4, side-buffer entries (power of two, >=2).
REQ-003 Parameter: STARVE_LIMIT, default 8, stalled cycles before force_redirect (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 buf_in_valid  input  1  redirected flit offered by redirect stage this cycle.
REQ-007 buf_in_flit  input  FLIT_W  redirected flit payload.
REQ-008 slot_free  input  4  empty pipeline lanes this cycle, bit0=N, bit1=S, bit2=E, bit3=W.
REQ-009 reinj_valid  output  1  head flit reinjected this cycle.
REQ-010 reinj_flit  output  FLIT_W  reinjected flit (head entry).
REQ-011 reinj_port  output  2  lane used: 0=N, 1=S, 2=E, 3=W.
REQ-012 count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 full / empty  output  1 each  count==DEPTH / count==0.
REQ-014 overflow  output  1  sticky; a flit was offered while full and dropped.
REQ-015 force_redirect  output  1  tells redirect stage to divert one flit to free a lane.

Function
REQ-016 Buffer SHALL be FIFO; reinjection order equals acceptance order.
REQ-017 reinj_valid SHALL equal !empty && |slot_free, combinational from registered state and slot_free.
REQ-018 reinj_port SHALL select lowest-index set bit of slot_free (N > S > E > W priority); value 0 when reinj_valid=0.
REQ-019 reinj_flit SHALL present head entry whenever !empty; all-zero when empty.
REQ-020 Head SHALL pop on the edge ending a cycle with reinj_valid=1.
REQ-021 Write accepted when buf_in_valid && (!full || reinj_valid); simultaneous push/pop leaves count unchanged.
REQ-022 Flit accepted at edge k SHALL NOT be reinjected before cycle following edge k (no bypass when empty).
REQ-023 Write when full with no pop SHALL drop flit, set overflow, leave FIFO unchanged.
REQ-024 Pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-025 Control FSM states: IDLE (empty), DRAIN (non-empty, reinjecting or waiting < STARVE_LIMIT), STARVE (force_redirect asserted).
REQ-026 IDLE->DRAIN on accepted write; DRAIN->IDLE when last entry pops with no write.
REQ-027 Stall counter increments each cycle !empty && slot_free==0, saturates at STARVE_LIMIT, clears on any pop or when empty.
REQ-028 DRAIN->STARVE on edge where counter reaches STARVE_LIMIT; force_redirect=1 exactly in STARVE.
REQ-029 STARVE->DRAIN (or IDLE if emptied) on edge ending a cycle with reinj_valid=1.

Reset
REQ-030 rst at any edge, including mid-burst, SHALL empty FIFO, clear pointers, stall counter, overflow, return FSM to IDLE; buffered flits discarded.
REQ-031 During/after reset: reinj_valid=0, reinj_port=0, reinj_flit=0, count=0, empty=1, full=0, overflow=0, force_redirect=0.
REQ-032 rst SHALL dominate simultaneous buf_in_valid.

Configuration
REQ-033 Macro SIDEBUF_STARVE_EN defined: stall counter, STARVE state, force_redirect per REQ-027..029.
REQ-034 Macro undefined: no stall counter, STARVE state unreachable/absent, force_redirect tied 0; all else unchanged.

Verification
REQ-035 Push 0x524 at edge 1, slot_free=4'b0000 then 4'b0110 at cycle 3 -> reinj_valid=1, reinj_port=1, reinj_flit=0x524, empty next cycle.
REQ-036 Push 5 flits with slot_free=0, DEPTH=4 -> count=4, full=1, overflow=1, fifth flit never reinjected.
REQ-037 Full FIFO, buf_in_valid=1 and slot_free=4'b1000 same cycle -> reinj_port=3, count stays 4, overflow stays 0.
REQ-038 SIDEBUF_STARVE_EN, one flit, slot_free=0 for 8 cycles -> force_redirect=1 from 9th cycle until slot_free=4'b0001 reinjection, then 0.
REQ-039 Three flits queued, rst pulsed one cycle -> all outputs at REQ-031 values; later slot_free=4'b1111 yields no reinjection.
REQ-040 Twelve push/pop cycles with DEPTH=4 -> output sequence matches input order across pointer wrap.

Source files
------------

// File: rtl/sidebuf_reinject.sv
// Side buffer that parks redirected flits and reinjects them, in arrival order, into free pipeline lanes.
// Define SIDEBUF_STARVE_EN to build the stall counter, STARVE state and force_redirect request.
module sidebuf_reinject #(
   parameter int FLIT_W       = 11,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     buf_in_valid,
   input  logic [FLIT_W-1:0]        buf_in_flit,
   input  logic [3:0]               slot_free,
   output logic                     reinj_valid,
   output logic [FLIT_W-1:0]        reinj_flit,
   output logic [1:0]               reinj_port,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     force_redirect
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, STARVE} state_t;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   state_t            state_q, state_d;
   logic              push, pop, starve_hit;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign pop         = !empty && (|slot_free);
   assign reinj_valid = pop;
   // A pop in the same cycle frees the slot, so a full buffer can still accept.
   assign push        = buf_in_valid && (!full || pop);
   assign reinj_flit  = empty ? '0 : mem[rd_ptr_q];

   always_comb begin
      reinj_port = 2'd0;
      if (pop) begin
         if (slot_free[0])      reinj_port = 2'd0;
         else if (slot_free[1]) reinj_port = 2'd1;
         else if (slot_free[2]) reinj_port = 2'd2;
         else                   reinj_port = 2'd3;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (buf_in_valid && !push);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

`ifdef SIDEBUF_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] stall_q, stall_d;

   // Counts only cycles with something queued and no lane to use.
   always_comb begin
      stall_d = stall_q;
      if (empty || pop)
         stall_d = '0;
      else if (stall_q != SW'(STARVE_LIMIT))
         stall_d = stall_q + SW'(1);
   end

   assign starve_hit = (stall_d == SW'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   always_comb begin
      force_redirect = (state_q == STARVE);
   end
`else
   assign starve_hit = 1'b0;

   always_comb begin
      force_redirect = 1'b0;
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_d != '0) state_d = DRAIN;
         DRAIN: begin
            if (count_d == '0)   state_d = IDLE;
            else if (starve_hit) state_d = STARVE;
         end
         STARVE:  if (pop) state_d = (count_d == '0) ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr_q] <= buf_in_flit;
   end
endmodule

// File: tb/tb_sidebuf_reinject.sv
// Directed, table-driven bench for sidebuf_reinject (DEPTH=4, FLIT_W=11, STARVE_LIMIT=8).
module tb_sidebuf_reinject;
   logic        clk = 1'b0;
   logic        rst;
   logic        buf_in_valid;
   logic [10:0] buf_in_flit;
   logic [3:0]  slot_free;
   logic        reinj_valid;
   logic [10:0] reinj_flit;
   logic [1:0]  reinj_port;
   logic [2:0]  count;
   logic        full, empty, overflow, force_redirect;

   int checks = 0;
   int errors = 0;

`ifdef SIDEBUF_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   sidebuf_reinject #(.FLIT_W(11), .DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst), .buf_in_valid(buf_in_valid), .buf_in_flit(buf_in_flit),
      .slot_free(slot_free), .reinj_valid(reinj_valid), .reinj_flit(reinj_flit),
      .reinj_port(reinj_port), .count(count), .full(full), .empty(empty),
      .overflow(overflow), .force_redirect(force_redirect)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        in_v;
      logic [10:0] in_f;
      logic [3:0]  slot;
      logic        e_v;
      logic [1:0]  e_port;
      logic [10:0] e_flit;
      logic [2:0]  e_cnt;
      logic        e_full;
      logic        e_empty;
      logic        e_ovf;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " reinj_valid"}, 32'(reinj_valid), 32'd0);
      chk({tag, " reinj_port"}, 32'(reinj_port), 32'd0);
      chk({tag, " reinj_flit"}, 32'(reinj_flit), 32'd0);
      chk({tag, " count"}, 32'(count), 32'd0);
      chk({tag, " empty"}, 32'(empty), 32'd1);
      chk({tag, " full"}, 32'(full), 32'd0);
      chk({tag, " overflow"}, 32'(overflow), 32'd0);
      chk({tag, " force_redirect"}, 32'(force_redirect), 32'd0);
   endtask

   logic [10:0] q [$];

   initial begin
      //          in_v  in_f     slot     e_v   port  e_flit   cnt   full  empty ovf
      vecs[0]  = {1'b1, 11'h524, 4'b0000, 1'b0, 2'd0, 11'h000, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = {1'b0, 11'h000, 4'b0000, 1'b0, 2'd0, 11'h524, 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = {1'b0, 11'h000, 4'b0110, 1'b1, 2'd1, 11'h524, 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = {1'b0, 11'h000, 4'b0000, 1'b0, 2'd0, 11'h000, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = {1'b1, 11'h111, 4'b1111, 1'b0, 2'd0, 11'h000, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = {1'b0, 11'h000, 4'b1111, 1'b1, 2'd0, 11'h111, 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = {1'b1, 11'h001, 4'b0000, 1'b0, 2'd0, 11'h000, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = {1'b1, 11'h002, 4'b0000, 1'b0, 2'd0, 11'h001, 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = {1'b1, 11'h003, 4'b0000, 1'b0, 2'd0, 11'h001, 3'd2, 1'b0, 1'b0, 1'b0};
      vecs[9]  = {1'b1, 11'h004, 4'b0000, 1'b0, 2'd0, 11'h001, 3'd3, 1'b0, 1'b0, 1'b0};
      vecs[10] = {1'b1, 11'h005, 4'b1000, 1'b1, 2'd3, 11'h001, 3'd4, 1'b1, 1'b0, 1'b0};
      vecs[11] = {1'b0, 11'h000, 4'b0000, 1'b0, 2'd0, 11'h002, 3'd4, 1'b1, 1'b0, 1'b0};
      vecs[12] = {1'b1, 11'h7FF, 4'b0000, 1'b0, 2'd0, 11'h002, 3'd4, 1'b1, 1'b0, 1'b0};
      vecs[13] = {1'b0, 11'h000, 4'b0000, 1'b0, 2'd0, 11'h002, 3'd4, 1'b1, 1'b0, 1'b1};
      vecs[14] = {1'b0, 11'h000, 4'b0100, 1'b1, 2'd2, 11'h002, 3'd4, 1'b1, 1'b0, 1'b1};
      vecs[15] = {1'b0, 11'h000, 4'b1010, 1'b1, 2'd1, 11'h003, 3'd3, 1'b0, 1'b0, 1'b1};
      vecs[16] = {1'b0, 11'h000, 4'b1100, 1'b1, 2'd2, 11'h004, 3'd2, 1'b0, 1'b0, 1'b1};
      vecs[17] = {1'b0, 11'h000, 4'b0001, 1'b1, 2'd0, 11'h005, 3'd1, 1'b0, 1'b0, 1'b1};
      vecs[18] = {1'b0, 11'h000, 4'b1111, 1'b0, 2'd0, 11'h000, 3'd0, 1'b0, 1'b1, 1'b1};

      rst = 1'b1;
      buf_in_valid = 1'b0;
      buf_in_flit = '0;
      slot_free = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      $display("reset: valid=%0d count=%0d empty=%0d", reinj_valid, count, empty);
      rst = 1'b0;

      // Table: basic reinjection, no bypass, full with pop, overflow drop, drain order.
      for (int i = 0; i < 19; i++) begin
         buf_in_valid = vecs[i].in_v;
         buf_in_flit  = vecs[i].in_f;
         slot_free    = vecs[i].slot;
         #1;
         $display("vec %0d: in_v=%0d slot=%b valid=%0d port=%0d flit=%h count=%0d full=%0d empty=%0d ovf=%0d",
                  i, vecs[i].in_v, vecs[i].slot, reinj_valid, reinj_port, reinj_flit, count, full, empty, overflow);
         chk($sformatf("vec%0d reinj_valid", i), 32'(reinj_valid), 32'(vecs[i].e_v));
         chk($sformatf("vec%0d reinj_port", i), 32'(reinj_port), 32'(vecs[i].e_port));
         chk($sformatf("vec%0d reinj_flit", i), 32'(reinj_flit), 32'(vecs[i].e_flit));
         chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].e_full));
         chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
         chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
         chk($sformatf("vec%0d force_redirect", i), 32'(force_redirect), 32'd0);
         next_cycle();
      end

      // Reset mid-burst with three flits queued and a simultaneous offer.
      buf_in_valid = 1'b0;
      slot_free = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         buf_in_valid = 1'b1;
         buf_in_flit = 11'h0A0 + 11'(i);
         next_cycle();
      end
      #1;
      chk("midburst count", 32'(count), 32'd3);
      rst = 1'b1;
      buf_in_valid = 1'b1;
      buf_in_flit = 11'h3C3;
      slot_free = 4'b1111;
      next_cycle();
      rst = 1'b0;
      buf_in_valid = 1'b0;
      #1;
      check_idle_outputs("post_rst");
      $display("post-reset: valid=%0d count=%0d ovf=%0d", reinj_valid, count, overflow);
      next_cycle();
      check_idle_outputs("post_rst2");

      // Push/pop mix across several pointer wraps, scoreboarded with a queue.
      for (int i = 0; i < 16; i++) begin
         logic exp_pop;
         logic acc;
         buf_in_valid = (i < 12);
         buf_in_flit = 11'h100 + 11'(i);
         slot_free = (i < 12 && (i % 3) == 0) ? 4'b0000 : 4'b0001;
         #1;
         exp_pop = (q.size() > 0) && (slot_free != 4'b0000);
         acc = buf_in_valid && (q.size() < 4 || exp_pop);
         chk($sformatf("wrap%0d count", i), 32'(count), 32'(q.size()));
         chk($sformatf("wrap%0d reinj_valid", i), 32'(reinj_valid), 32'(exp_pop));
         if (exp_pop) begin
            chk($sformatf("wrap%0d reinj_flit", i), 32'(reinj_flit), 32'(q[0]));
            void'(q.pop_front());
         end
         if (acc) q.push_back(buf_in_flit);
         $display("wrap %0d: valid=%0d flit=%h count=%0d", i, reinj_valid, reinj_flit, count);
         next_cycle();
      end
      buf_in_valid = 1'b0;
      #1;
      chk("wrap final empty", 32'(empty), 32'd1);

      // Starvation: one flit, no free lane for ten cycles, then lane N frees up.
      slot_free = 4'b0000;
      buf_in_valid = 1'b1;
      buf_in_flit = 11'h2AB;
      next_cycle();
      buf_in_valid = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         #1;
         chk($sformatf("starve%0d force_redirect", n), 32'(force_redirect), 32'(STARVE_EN && n >= 9));
         chk($sformatf("starve%0d reinj_valid", n), 32'(reinj_valid), 32'd0);
         $display("starve cycle %0d: force_redirect=%0d", n, force_redirect);
         next_cycle();
      end
      slot_free = 4'b0001;
      #1;
      chk("starve release reinj_valid", 32'(reinj_valid), 32'd1);
      chk("starve release reinj_port", 32'(reinj_port), 32'd0);
      chk("starve release reinj_flit", 32'(reinj_flit), 32'h2AB);
      chk("starve release force_redirect", 32'(force_redirect), 32'(STARVE_EN));
      next_cycle();
      slot_free = 4'b0000;
      #1;
      chk("starve after force_redirect", 32'(force_redirect), 32'd0);
      chk("starve after empty", 32'(empty), 32'd1);
      $display("starve done: force_redirect=%0d empty=%0d", force_redirect, empty);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
